// File: rtl/inject_pkg.sv
// Shared definitions for the injection scheduler.
// - state_t : scheduler FSM states.
// - idx_w   : bits needed to index n items (minimum 1).
// - cnt_w   : bits needed to hold the value n itself.
package inject_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    RUN,
    DRAIN,
    DONE
  } state_t;

  function automatic int unsigned idx_w(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  function automatic int unsigned cnt_w(input int unsigned n);
    return (n > 0) ? $clog2(n + 1) : 1;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter.
// The search starts one past i_ptr and wraps, so the most recent winner has
// the lowest priority.
//   i_req       : request vector
//   i_ptr       : index of the previous winner
//   o_grant     : one-hot grant
//   o_grant_idx : index of the granted request
//   o_any_grant : at least one request was granted
module rr_arbiter
  import inject_pkg::*;
#(
  parameter int unsigned NUM_SRC = 4
) (
  input  logic [NUM_SRC-1:0]          i_req,
  input  logic [idx_w(NUM_SRC)-1:0]   i_ptr,
  output logic [NUM_SRC-1:0]          o_grant,
  output logic [idx_w(NUM_SRC)-1:0]   o_grant_idx,
  output logic                        o_any_grant
);

  localparam int unsigned PW = idx_w(NUM_SRC);

  logic [PW-1:0] w_idx;

  always_comb begin
    o_grant     = '0;
    o_grant_idx = '0;
    o_any_grant = 1'b0;
    w_idx       = '0;
    for (int unsigned k = 1; k <= NUM_SRC; k++) begin
      w_idx = PW'((32'(i_ptr) + k) % NUM_SRC);
      if (!o_any_grant && i_req[w_idx]) begin
        o_grant[w_idx] = 1'b1;
        o_grant_idx    = w_idx;
        o_any_grant    = 1'b1;
      end
    end
  end

endmodule

// File: rtl/inject_scheduler.sv
// Injection sequencer for the flattened-butterfly harness.
// The scheduler rewinds the input buffers and then paces each masked source
// with a programmable gap. It arbitrates one issue per cycle round-robin.
// After the last issue it waits DRAIN_CYCLES cycles and then raises done.
//   clk, rst     : clock, asynchronous active-low reset
//   start, stop  : run control pulses (stop has priority)
//   src_mask     : participating sources, latched at start
//   inj_gap      : idle cycles between issues of one source, latched at start
//   router_ready : per-port accept
//   buf_rst      : rewind pulse to the buffers (during LOAD)
//   buf_en_n     : active-low per-buffer advance
//   buf_valid    : per-buffer valid, checked against the expected copy
//   busy, done   : status outputs
//   total_issued : issue count for this run (saturating)
//   err          : sticky valid-mismatch flag
module inject_scheduler
  import inject_pkg::*;
#(
  parameter int unsigned NUM_SRC      = 4,
  parameter int unsigned TEST_CASES   = 5,
  parameter int unsigned GAP_W        = 8,
  parameter int unsigned DRAIN_CYCLES = 32,
  parameter int unsigned CNT_W        = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               stop,
  input  logic [NUM_SRC-1:0] src_mask,
  input  logic [GAP_W-1:0]   inj_gap,
  input  logic [NUM_SRC-1:0] router_ready,
  output logic               buf_rst,
  output logic [NUM_SRC-1:0] buf_en_n,
  input  logic [NUM_SRC-1:0] buf_valid,
  output logic               busy,
  output logic               done,
  output logic [CNT_W-1:0]   total_issued,
  output logic               err
);

  localparam int unsigned PW = idx_w(NUM_SRC);
  localparam int unsigned IW = cnt_w(TEST_CASES);
  localparam int unsigned DW = idx_w(DRAIN_CYCLES);

  state_t             r_state, w_state_nxt;
  logic [NUM_SRC-1:0] r_mask, r_buf_en_n, r_exp_valid;
  logic [GAP_W-1:0]   r_gap_lat;
  logic [GAP_W-1:0]   r_gap_cnt [NUM_SRC];
  logic [IW-1:0]      r_issued  [NUM_SRC];
  logic [PW-1:0]      r_ptr;
  logic [DW-1:0]      r_drain_cnt;
  logic [CNT_W-1:0]   r_total;
  logic               r_buf_rst, r_busy, r_done, r_err;

  logic [NUM_SRC-1:0] w_req, w_grant;
  logic [PW-1:0]      w_grant_idx;
  logic               w_any_grant, w_all_done, w_drain_last;

  // Requests are blocked while stop is asserted. This keeps an abort from
  // leaving a stray advance pulse behind in IDLE.
  always_comb begin
    w_req      = '0;
    w_all_done = 1'b1;
    for (int unsigned i = 0; i < NUM_SRC; i++) begin
      if (r_mask[i] && (r_issued[i] != IW'(TEST_CASES))) w_all_done = 1'b0;
      w_req[i] = (r_state == RUN) && !stop && r_mask[i] &&
                 (r_gap_cnt[i] == '0) && (r_issued[i] < IW'(TEST_CASES)) &&
                 router_ready[i];
    end
  end

  assign w_drain_last = (r_drain_cnt == DW'(DRAIN_CYCLES - 1));

  rr_arbiter #(.NUM_SRC(NUM_SRC)) u_arb (
    .i_req       (w_req),
    .i_ptr       (r_ptr),
    .o_grant     (w_grant),
    .o_grant_idx (w_grant_idx),
    .o_any_grant (w_any_grant)
  );

  always_comb begin
    w_state_nxt = r_state;
    if (stop) begin
      w_state_nxt = IDLE;
    end else begin
      case (r_state)
        IDLE, DONE: if (start) w_state_nxt = LOAD;
        LOAD:       w_state_nxt = RUN;
        RUN:        if (w_all_done) w_state_nxt = DRAIN;
        DRAIN:      if (w_drain_last) w_state_nxt = DONE;
        default:    w_state_nxt = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= IDLE;
    else      r_state <= w_state_nxt;
  end

  // Status outputs are registered from the next state so that they line up
  // with the state they describe.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_buf_rst   <= 1'b0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_buf_en_n  <= '1;
      r_exp_valid <= '0;
      r_mask      <= '0;
      r_gap_lat   <= '0;
      r_ptr       <= PW'(NUM_SRC - 1);
      r_drain_cnt <= '0;
      r_total     <= '0;
      r_err       <= 1'b0;
      for (int unsigned i = 0; i < NUM_SRC; i++) begin
        r_gap_cnt[i] <= '0;
        r_issued[i]  <= '0;
      end
    end else begin
      r_buf_rst   <= (w_state_nxt == LOAD);
      r_busy      <= (w_state_nxt == LOAD) || (w_state_nxt == RUN) ||
                     (w_state_nxt == DRAIN);
      r_done      <= (w_state_nxt == DONE);
      r_buf_en_n  <= ~w_grant;
      r_exp_valid <= ~r_buf_en_n;
      r_drain_cnt <= (r_state == DRAIN) ? r_drain_cnt + 1'b1 : '0;

      if (w_state_nxt == LOAD) begin
        r_mask    <= src_mask;
        r_gap_lat <= inj_gap;
        r_ptr     <= PW'(NUM_SRC - 1);
        r_total   <= '0;
        r_err     <= 1'b0;
        for (int unsigned i = 0; i < NUM_SRC; i++) begin
          r_gap_cnt[i] <= '0;
          r_issued[i]  <= '0;
        end
      end else begin
        for (int unsigned i = 0; i < NUM_SRC; i++) begin
          if (w_grant[i]) begin
            r_gap_cnt[i] <= r_gap_lat;
            r_issued[i]  <= r_issued[i] + 1'b1;
          end else if (r_gap_cnt[i] != '0) begin
            r_gap_cnt[i] <= r_gap_cnt[i] - 1'b1;
          end
        end
        if (w_any_grant) r_ptr <= w_grant_idx;
        if (w_any_grant && (r_total != '1)) r_total <= r_total + 1'b1;
        if (((r_state == RUN) || (r_state == DRAIN)) && (buf_valid != r_exp_valid))
          r_err <= 1'b1;
      end
    end
  end

  assign buf_rst      = r_buf_rst;
  assign buf_en_n     = r_buf_en_n;
  assign busy         = r_busy;
  assign done         = r_done;
  assign total_issued = r_total;
  assign err          = r_err;

endmodule

// File: tb/tb_inject_scheduler.sv
// Self-checking bench for inject_scheduler with the default parameters.
// The bench contains a registered buffer model, so buf_valid follows ~buf_en_n
// one cycle later.
module tb_inject_scheduler;

  logic        clk, rst, start, stop;
  logic [3:0]  src_mask, router_ready, buf_en_n, buf_valid;
  logic [7:0]  inj_gap;
  logic        buf_rst, busy, done, err;
  logic [15:0] total_issued;
  logic [3:0]  vmodel, kill;

  int cyc = 0;
  int total_cnt = 0;
  int bad_cnt = 0;
  int pulses[4];
  int log_src[$];
  int log_cyc[$];

  inject_scheduler #(
    .NUM_SRC(4), .TEST_CASES(5), .GAP_W(8), .DRAIN_CYCLES(32), .CNT_W(16)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .stop(stop),
    .src_mask(src_mask), .inj_gap(inj_gap), .router_ready(router_ready),
    .buf_rst(buf_rst), .buf_en_n(buf_en_n), .buf_valid(buf_valid),
    .busy(busy), .done(done), .total_issued(total_issued), .err(err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk or negedge rst)
    if (!rst) vmodel <= '0;
    else      vmodel <= ~buf_en_n;
  assign buf_valid = vmodel & ~kill;

  always @(negedge clk)
    for (int i = 0; i < 4; i++)
      if (!buf_en_n[i]) begin
        pulses[i]++;
        log_src.push_back(i);
        log_cyc.push_back(cyc);
      end

  typedef struct {
    logic [3:0] mask;
    logic [7:0] gap;
    int         exp_total;
    int         exp_lat;   // posedges from the start edge to done
    int         step;      // pulse k seen at start+2+k*step; 0 means not checked
  } vec_t;
  vec_t vecs[6];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act !== exp) begin
      bad_cnt++;
      $display("FAIL %s: got %0d want %0d", name, act, exp);
    end
  endtask

  task automatic clear_log();
    for (int i = 0; i < 4; i++) pulses[i] = 0;
    log_src.delete();
    log_cyc.delete();
  endtask

  task automatic start_run(input logic [3:0] m, input logic [7:0] g, output int p);
    @(negedge clk);
    clear_log();
    src_mask = m;
    inj_gap  = g;
    start    = 1'b1;
    @(negedge clk);
    start = 1'b0;
    p = cyc;
    chk("load_buf_rst", buf_rst, 1);
    chk("load_busy", busy, 1);
    chk("load_done", done, 0);
    chk("load_total", total_issued, 0);
    chk("load_err", err, 0);
    chk("load_en_n", buf_en_n, 4'hF);
    src_mask = '0;
    inj_gap  = '0;
  endtask

  task automatic wait_done(input int p, output int lat);
    lat = -1;
    for (int n = 0; n < 300; n++) begin
      if (done) begin
        lat = cyc - p;
        break;
      end
      @(negedge clk);
    end
    chk("done_seen", done, 1);
  endtask

  initial begin
    int p, lat, sb;
    int bl[$];

    vecs[0] = '{4'b1111, 8'd0, 20, 54, 1};
    vecs[1] = '{4'b0001, 8'd3,  5, 51, 4};
    vecs[2] = '{4'b0101, 8'd1, 10, 44, 1};
    vecs[3] = '{4'b1111, 8'd5, 20, 62, 0};
    vecs[4] = '{4'b1000, 8'd0,  5, 39, 1};
    vecs[5] = '{4'b0110, 8'd0, 10, 44, 1};

    rst = 1'b0; start = 1'b0; stop = 1'b0;
    src_mask = '0; inj_gap = '0; router_ready = '1; kill = '0;
    repeat (3) @(negedge clk);
    chk("rst_en_n", buf_en_n, 4'hF);
    chk("rst_buf_rst", buf_rst, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_total", total_issued, 0);
    chk("rst_err", err, 0);
    rst = 1'b1;
    @(negedge clk);

    for (int v = 0; v < 6; v++) begin
      start_run(vecs[v].mask, vecs[v].gap, p);
      @(negedge clk);
      chk($sformatf("v%0d_run_buf_rst", v), buf_rst, 0);
      wait_done(p, lat);
      chk($sformatf("v%0d_done_lat", v), lat, vecs[v].exp_lat);
      chk($sformatf("v%0d_total", v), total_issued, vecs[v].exp_total);
      chk($sformatf("v%0d_err", v), err, 0);
      chk($sformatf("v%0d_nlog", v), log_src.size(), vecs[v].exp_total);
      for (int i = 0; i < 4; i++)
        chk($sformatf("v%0d_pulses%0d", v, i), pulses[i], vecs[v].mask[i] ? 5 : 0);
      if (vecs[v].step != 0) begin
        bl.delete();
        for (int i = 0; i < 4; i++) if (vecs[v].mask[i]) bl.push_back(i);
        sb = 0;
        for (int k = 0; k < log_src.size(); k++)
          if (log_src[k] != bl[k % bl.size()] || log_cyc[k] - p != 2 + k * vecs[v].step)
            sb++;
        chk($sformatf("v%0d_seq", v), sb, 0);
      end
      repeat (3) @(negedge clk);
      chk($sformatf("v%0d_done_hold", v), done, 1);
      chk($sformatf("v%0d_idle_busy", v), busy, 0);
    end

    // Backpressure on source 2 for the first part of the run.
    router_ready = 4'b1011;
    start_run(4'b1111, 8'd0, p);
    while (cyc < p + 10) @(negedge clk);
    #1;
    chk("bp_src2_blocked", pulses[2], 0);
    chk("bp_others", pulses[0] + pulses[1] + pulses[3], 9);
    router_ready = '1;
    wait_done(p, lat);
    chk("bp_done_lat", lat, 54);
    chk("bp_total", total_issued, 20);
    for (int i = 0; i < 4; i++) chk($sformatf("bp_pulses%0d", i), pulses[i], 5);
    chk("bp_err", err, 0);

    // Abort: start and stop together while draining.
    start_run(4'b1111, 8'd0, p);
    while (cyc < p + 30) @(negedge clk);
    chk("ab_drain_busy", busy, 1);
    chk("ab_drain_total", total_issued, 20);
    start = 1'b1; stop = 1'b1;
    @(negedge clk);
    start = 1'b0; stop = 1'b0;
    chk("ab_busy", busy, 0);
    chk("ab_done", done, 0);
    chk("ab_buf_rst", buf_rst, 0);
    chk("ab_en_n", buf_en_n, 4'hF);
    repeat (2) @(negedge clk);
    chk("ab_stay_idle", busy, 0);
    start_run(4'b1111, 8'd0, p);
    wait_done(p, lat);
    chk("ab_rerun_lat", lat, 54);
    chk("ab_rerun_total", total_issued, 20);

    // Drop buf_valid[1] on the cycle it is expected.
    start_run(4'b1111, 8'd0, p);
    while (cyc < p + 4) @(negedge clk);
    kill = 4'b0010;
    chk("er_before", err, 0);
    @(negedge clk);
    kill = '0;
    chk("er_set", err, 1);
    wait_done(p, lat);
    chk("er_sticky", err, 1);
    chk("er_total", total_issued, 20);

    // Empty mask: run finishes with no issues, err cleared by LOAD.
    start_run(4'b0000, 8'd0, p);
    wait_done(p, lat);
    chk("m0_lat", lat, 34);
    chk("m0_total", total_issued, 0);
    chk("m0_err", err, 0);
    chk("m0_nlog", log_src.size(), 0);

    // Asynchronous reset in the middle of RUN, then a fresh run.
    start_run(4'b1111, 8'd0, p);
    while (cyc < p + 8) @(negedge clk);
    chk("ar_pre_total", total_issued, 7);
    #2 rst = 1'b0;
    #1;
    chk("ar_busy", busy, 0);
    chk("ar_en_n", buf_en_n, 4'hF);
    chk("ar_total", total_issued, 0);
    chk("ar_done", done, 0);
    chk("ar_buf_rst", buf_rst, 0);
    chk("ar_err", err, 0);
    @(negedge clk);
    rst = 1'b1;
    start_run(4'b1111, 8'd0, p);
    wait_done(p, lat);
    chk("ar_rerun_lat", lat, 54);
    chk("ar_rerun_total", total_issued, 20);
    for (int i = 0; i < 4; i++) chk($sformatf("ar_pulses%0d", i), pulses[i], 5);

    $display("test done: total=%0d bad=%0d", total_cnt, bad_cnt);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog expired");
  end

endmodule
